ovl_next_window: RTL and testbench
==================================

Name: ovl_next_window

Overview:
- Parametrised successor to the single-shot next checker.
- Monitors NUM_CH independent start_event/test_expr channel pairs.
- Requires test_expr within a window of [MIN_CKS, MAX_CKS] clocks after each start_event.
- Flags early, late, overlapping-start and missing-start violations per channel, and keeps a saturating violation count.
- Instantiated in benches alongside the other OVL checkers and driven by the common clock generator.

Parameters:
- NUM_CH, 2: number of independent channels (1..32).
- MIN_CKS, 1: earliest legal response delay in clocks (>=1).
- MAX_CKS, 4: latest legal response delay in clocks (MIN_CKS..255).
- CHECK_OVERLAP, 1: when 1, a start_event while a channel is pending is an error.
- CHECK_MISSING_START, 0: when 1, test_expr while a channel is idle is an error.

Ports:
- clock  in  1  sampling clock; all state on posedge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  global checker enable.
- start_event  in  NUM_CH  per-channel start.
- test_expr  in  NUM_CH  per-channel response.
- fire_early  out  NUM_CH  response before MIN_CKS.
- fire_late  out  NUM_CH  no response by MAX_CKS.
- fire_overlap  out  NUM_CH  restart while pending.
- fire_missing  out  NUM_CH  response with no start.
- err_count  out  16  saturating total of violations.

Behaviour:
- Reset: all channels IDLE, counters 0, all fire_* 0, err_count 0. Reset mid-window abandons the window silently.
- enable=0: channels forced to IDLE, no fire bits generated, err_count holds.
- Per-channel FSM has states IDLE and PEND, with an 8-bit count cnt.
- IDLE transitions:
  - start_event -> PEND, cnt<=1.
  - test_expr in the same cycle as start_event is not evaluated.
  - test_expr && !start_event && CHECK_MISSING_START -> missing violation; stay IDLE.
- PEND transitions (cnt=c means the current edge is k=c clocks after start):
  - test_expr && c<MIN_CKS -> early violation; -> IDLE.
  - test_expr && c>=MIN_CKS -> pass; -> IDLE.
  - !test_expr && c==MAX_CKS -> late violation; -> IDLE.
  - Otherwise cnt<=c+1.
- Simultaneous start_event in PEND:
  - On an edge that resolves the window (pass/early/late): the old window resolves as above, then the new start loads PEND with cnt=1. No overlap error.
  - On a non-resolving edge with CHECK_OVERLAP=1: overlap violation; window restarts with cnt=1.
  - On a non-resolving edge with CHECK_OVERLAP=0: start ignored; the original window continues.
- Fire timing: fire_* are registered one-cycle pulses, asserted on the edge after the violating sample (latency 1). Multiple channels may fire in the same cycle; a channel fires at most one type per cycle.
- err_count: increments by the popcount of all fire bits generated this cycle, saturating at 16'hFFFF, with no wrap.
- Elaboration error if MIN_CKS<1, MAX_CKS<MIN_CKS, MAX_CKS>255 or NUM_CH>32.

Optional Feature:
- Macro: OVL_NEXT_WINDOW_COVER_EN.
- Defined:
  - Adds output pass_count[15:0]: saturating count of passed windows across all channels, reset 0, updated with the same 1-cycle latency as fire_*.
  - Adds output pend_max[7:0]: maximum number of simultaneously PEND channels seen since reset.
- Undefined: neither port nor its logic exists. All other behaviour is identical.

Decomposition:
- Package ovl_next_window_pkg:
  - channel state enum {IDLE, PEND}.
  - violation-type enum {V_NONE, V_EARLY, V_LATE, V_OVERLAP, V_MISSING}.
  - ERR_CNT_W=16, CNT_W=8.
  - Saturating-add function.
- Sub-module ovl_next_window_chan: one channel FSM plus counter, emitting a registered violation type and pass pulse. Instantiated NUM_CH times by generate.
- The top level holds fire decode, popcount and err_count.

Test Plan (NUM_CH=2, MIN_CKS=2, MAX_CKS=4, CHECK_OVERLAP=1, CHECK_MISSING_START=1):
- Legal response: ch0 start at edge t, test_expr at t+3 -> no fire; err_count stays 0; pass_count=1 when the cover macro is defined.
- Early and late: ch0 test_expr at t+1 -> fire_early[0] pulses at t+2. ch1 start with no response -> fire_late[1] pulses at t+5. err_count=2.
- Overlap: ch0 start at t and again at t+2, test_expr at t+4 -> fire_overlap[0] at t+3, pass at t+4 (k=2), err_count=1.
- Resolve plus restart: ch0 start at t, then test_expr and start_event both at t+2 -> no fire. The new window passes with test_expr at t+5.
- Missing start and simultaneous channels: test_expr on both channels in IDLE -> fire_missing=2'b11 in one cycle; err_count increments by 2.
- Reset and saturation:
  - reset asserted at t+2 of a pending window -> no fire afterwards, all outputs 0.
  - Forcing 65540 missing violations -> err_count holds at 16'hFFFF.

Source files
------------

// File: rtl/ovl_next_window_pkg.sv
// ----------------------------------------------------------------------------
// ovl_next_window_pkg
// Shared types and helpers for the ovl_next_window checker:
//   chan_state_t : per-channel window state (IDLE / PEND)
//   viol_t       : violation type carried from a channel to the top level
//   ERR_CNT_W    : width of the saturating violation / pass counters
//   CNT_W        : width of the per-channel clock counter
//   sat_add      : unsigned add that clamps at all-ones instead of wrapping
// ----------------------------------------------------------------------------
package ovl_next_window_pkg;

    localparam int ERR_CNT_W = 16;
    localparam int CNT_W     = 8;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } chan_state_t;

    typedef enum logic [2:0] {
        V_NONE    = 3'd0,
        V_EARLY   = 3'd1,
        V_LATE    = 3'd2,
        V_OVERLAP = 3'd3,
        V_MISSING = 3'd4
    } viol_t;

    function automatic logic [ERR_CNT_W-1:0] sat_add(
        input logic [ERR_CNT_W-1:0] a,
        input logic [ERR_CNT_W-1:0] b
    );
        logic [ERR_CNT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[ERR_CNT_W] ? {ERR_CNT_W{1'b1}} : s[ERR_CNT_W-1:0];
    endfunction

endpackage

// File: rtl/ovl_next_window_chan.sv
// ----------------------------------------------------------------------------
// ovl_next_window_chan
// One checker channel: IDLE/PEND window FSM with an 8-bit clock counter.
// The violation found on an edge is registered here (viol), so the top level
// sees it one edge after the offending sample.
//
// Optional build macro: OVL_NEXT_WINDOW_COVER_EN (adds pass / pend outputs)
//
// Ports:
//   clock       in   sampling clock, all state on posedge
//   reset       in   synchronous active-high reset
//   enable      in   checker enable; low forces IDLE
//   start_event in   window start
//   test_expr   in   response
//   pass        out  registered pulse: a window passed (cover build only)
//   pend        out  channel currently PEND (cover build only)
//   viol        out  registered violation type of the previous edge
// ----------------------------------------------------------------------------
module ovl_next_window_chan
    import ovl_next_window_pkg::*;
#(
    parameter int MIN_CKS             = 1,
    parameter int MAX_CKS             = 4,
    parameter int CHECK_OVERLAP       = 1,
    parameter int CHECK_MISSING_START = 0
) (
    input  logic  clock,
    input  logic  reset,
    input  logic  enable,
    input  logic  start_event,
    input  logic  test_expr,
`ifdef OVL_NEXT_WINDOW_COVER_EN
    output logic  pass,
    output logic  pend,
`endif
    output viol_t viol
);

    localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_CKS);
    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_CKS);
    localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

    chan_state_t      state_p0, state_nx;
    logic [CNT_W-1:0] cnt_p0, cnt_nx;
    viol_t            viol_nx, viol_p1;
    logic             resolve;
`ifdef OVL_NEXT_WINDOW_COVER_EN
    logic             pass_nx, pass_p1;
`endif

    always_comb begin
        state_nx = state_p0;
        cnt_nx   = cnt_p0;
        viol_nx  = V_NONE;
        resolve  = 1'b0;
`ifdef OVL_NEXT_WINDOW_COVER_EN
        pass_nx  = 1'b0;
`endif
        if (!enable) begin
            state_nx = IDLE;
            cnt_nx   = '0;
        end else begin
            case (state_p0)
                IDLE: begin
                    // A response coinciding with a start is not evaluated.
                    if (start_event) begin
                        state_nx = PEND;
                        cnt_nx   = ONE_C;
                    end else if (test_expr && (CHECK_MISSING_START != 0)) begin
                        viol_nx = V_MISSING;
                    end
                end
                PEND: begin
                    // cnt_p0 is the number of clocks since the start edge.
                    if (test_expr) begin
                        resolve  = 1'b1;
                        state_nx = IDLE;
                        if (cnt_p0 < MIN_C) viol_nx = V_EARLY;
`ifdef OVL_NEXT_WINDOW_COVER_EN
                        else pass_nx = 1'b1;
`endif
                    end else if (cnt_p0 == MAX_C) begin
                        resolve  = 1'b1;
                        state_nx = IDLE;
                        viol_nx  = V_LATE;
                    end else begin
                        cnt_nx = cnt_p0 + ONE_C;
                    end
                    // A start on a resolving edge simply opens the next window;
                    // otherwise it is either an overlap restart or ignored.
                    if (start_event) begin
                        if (resolve) begin
                            state_nx = PEND;
                            cnt_nx   = ONE_C;
                        end else if (CHECK_OVERLAP != 0) begin
                            viol_nx = V_OVERLAP;
                            cnt_nx  = ONE_C;
                        end
                    end
                end
                default: begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end
            endcase
        end
    end

    // ---- stage p0 -> p1: window state and registered violation ----
    always_ff @(posedge clock) begin
        if (reset) begin
            state_p0 <= IDLE;
            cnt_p0   <= '0;
            viol_p1  <= V_NONE;
`ifdef OVL_NEXT_WINDOW_COVER_EN
            pass_p1  <= 1'b0;
`endif
        end else begin
            state_p0 <= state_nx;
            cnt_p0   <= cnt_nx;
            viol_p1  <= viol_nx;
`ifdef OVL_NEXT_WINDOW_COVER_EN
            pass_p1  <= pass_nx;
`endif
        end
    end

    assign viol = viol_p1;
`ifdef OVL_NEXT_WINDOW_COVER_EN
    assign pass = pass_p1;
    assign pend = (state_p0 == PEND);
`endif

endmodule

// File: rtl/ovl_next_window.sv
// ----------------------------------------------------------------------------
// ovl_next_window
// Multi-channel "next within a window" checker. Each channel requires
// test_expr between MIN_CKS and MAX_CKS clocks after start_event and reports
// early, late, overlapping-start and missing-start violations as registered
// one-cycle pulses, one edge after the channel registers the violation.
//
// Optional build macro: OVL_NEXT_WINDOW_COVER_EN
//   adds pass_count (saturating passed windows) and pend_max (peak number of
//   simultaneously pending channels since reset).
//
// Ports:
//   clock        in   sampling clock, all state on posedge
//   reset        in   synchronous active-high reset
//   enable       in   global checker enable
//   start_event  in   [NUM_CH] per-channel start
//   test_expr    in   [NUM_CH] per-channel response
//   fire_early   out  [NUM_CH] response before MIN_CKS
//   fire_late    out  [NUM_CH] no response by MAX_CKS
//   fire_overlap out  [NUM_CH] restart while pending
//   fire_missing out  [NUM_CH] response with no start
//   err_count    out  [16]     saturating total of violations
//   pass_count   out  [16]     saturating passed windows (cover build only)
//   pend_max     out  [8]      peak simultaneous PEND channels (cover build only)
// ----------------------------------------------------------------------------
module ovl_next_window
    import ovl_next_window_pkg::*;
#(
    parameter int NUM_CH              = 2,
    parameter int MIN_CKS             = 1,
    parameter int MAX_CKS             = 4,
    parameter int CHECK_OVERLAP       = 1,
    parameter int CHECK_MISSING_START = 0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [NUM_CH-1:0]    start_event,
    input  logic [NUM_CH-1:0]    test_expr,
    output logic [NUM_CH-1:0]    fire_early,
    output logic [NUM_CH-1:0]    fire_late,
    output logic [NUM_CH-1:0]    fire_overlap,
    output logic [NUM_CH-1:0]    fire_missing,
`ifdef OVL_NEXT_WINDOW_COVER_EN
    output logic [ERR_CNT_W-1:0] pass_count,
    output logic [7:0]           pend_max,
`endif
    output logic [ERR_CNT_W-1:0] err_count
);

    if (MIN_CKS < 1) begin : g_bad_min
        $error("ovl_next_window: MIN_CKS must be >= 1");
    end
    if (MAX_CKS < MIN_CKS) begin : g_bad_max_lo
        $error("ovl_next_window: MAX_CKS must be >= MIN_CKS");
    end
    if (MAX_CKS > 255) begin : g_bad_max_hi
        $error("ovl_next_window: MAX_CKS must be <= 255");
    end
    if (NUM_CH > 32 || NUM_CH < 1) begin : g_bad_ch
        $error("ovl_next_window: NUM_CH must be 1..32");
    end

    viol_t viol_p1 [NUM_CH];
`ifdef OVL_NEXT_WINDOW_COVER_EN
    logic [NUM_CH-1:0] pass_p1;
    logic [NUM_CH-1:0] pend_p0;
`endif

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        ovl_next_window_chan #(
            .MIN_CKS             (MIN_CKS),
            .MAX_CKS             (MAX_CKS),
            .CHECK_OVERLAP       (CHECK_OVERLAP),
            .CHECK_MISSING_START (CHECK_MISSING_START)
        ) u_chan (
            .clock       (clock),
            .reset       (reset),
            .enable      (enable),
            .start_event (start_event[g]),
            .test_expr   (test_expr[g]),
`ifdef OVL_NEXT_WINDOW_COVER_EN
            .pass        (pass_p1[g]),
            .pend        (pend_p0[g]),
`endif
            .viol        (viol_p1[g])
        );
    end

    logic [NUM_CH-1:0] early_d, late_d, overlap_d, missing_d;
    logic [5:0]        nfire;
`ifdef OVL_NEXT_WINDOW_COVER_EN
    logic [5:0]        npass, npend;
`endif

    // Fire bits are generated only while enabled, so a violation still in
    // flight when enable drops is discarded and err_count holds.
    always_comb begin
        early_d   = '0;
        late_d    = '0;
        overlap_d = '0;
        missing_d = '0;
        nfire     = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            early_d[i]   = enable && (viol_p1[i] == V_EARLY);
            late_d[i]    = enable && (viol_p1[i] == V_LATE);
            overlap_d[i] = enable && (viol_p1[i] == V_OVERLAP);
            missing_d[i] = enable && (viol_p1[i] == V_MISSING);
            nfire = nfire + 6'(enable && (viol_p1[i] != V_NONE));
        end
    end

`ifdef OVL_NEXT_WINDOW_COVER_EN
    always_comb begin
        npass = '0;
        npend = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            npass = npass + 6'(enable && pass_p1[i]);
            npend = npend + 6'(pend_p0[i]);
        end
    end
`endif

    // ---- stage p1 -> p2: fire pulses and counters ----
    always_ff @(posedge clock) begin
        if (reset) begin
            fire_early   <= '0;
            fire_late    <= '0;
            fire_overlap <= '0;
            fire_missing <= '0;
            err_count    <= '0;
`ifdef OVL_NEXT_WINDOW_COVER_EN
            pass_count   <= '0;
            pend_max     <= '0;
`endif
        end else begin
            fire_early   <= early_d;
            fire_late    <= late_d;
            fire_overlap <= overlap_d;
            fire_missing <= missing_d;
            err_count    <= sat_add(err_count, ERR_CNT_W'(nfire));
`ifdef OVL_NEXT_WINDOW_COVER_EN
            pass_count   <= sat_add(pass_count, ERR_CNT_W'(npass));
            if (8'(npend) > pend_max) pend_max <= 8'(npend);
`endif
        end
    end

endmodule

// File: tb/tb_ovl_next_window.sv
// ----------------------------------------------------------------------------
// tb_ovl_next_window
// Directed bench for ovl_next_window (NUM_CH=2, MIN_CKS=2, MAX_CKS=4,
// overlap and missing-start checks on). A timestamp-based model tracks the
// start edge of each open window and derives the expected fire pulses and
// counters; a negedge process compares the DUT against it every cycle, and
// literal checks pin the model at the points the scenarios call out.
// ----------------------------------------------------------------------------
module tb_ovl_next_window;

    localparam int NCH  = 2;
    localparam int MINC = 2;
    localparam int MAXC = 4;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic           enable = 1'b1;
    logic [NCH-1:0] st = '0;
    logic [NCH-1:0] te = '0;
    logic [NCH-1:0] fire_early, fire_late, fire_overlap, fire_missing;
    logic [15:0]    err_count;
`ifdef OVL_NEXT_WINDOW_COVER_EN
    logic [15:0]    pass_count;
    logic [7:0]     pend_max;
`endif

    always #5 clock = ~clock;

    ovl_next_window #(
        .NUM_CH(NCH), .MIN_CKS(MINC), .MAX_CKS(MAXC),
        .CHECK_OVERLAP(1), .CHECK_MISSING_START(1)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .start_event  (st),
        .test_expr    (te),
        .fire_early   (fire_early),
        .fire_late    (fire_late),
        .fire_overlap (fire_overlap),
        .fire_missing (fire_missing),
`ifdef OVL_NEXT_WINDOW_COVER_EN
        .pass_count   (pass_count),
        .pend_max     (pend_max),
`endif
        .err_count    (err_count)
    );

    int nvec = 0;
    int nerr = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---- model: window start edge per channel, two-edge fire latency ----
    int             n = 0;
    int             start_at [NCH] = '{-1, -1};
    logic [NCH-1:0] v_e = '0, v_l = '0, v_o = '0, v_m = '0;
    logic [NCH-1:0] x_e = '0, x_l = '0, x_o = '0, x_m = '0;
    int             v_pass = 0;
    int             exp_err = 0;
    int             exp_pass = 0;

    always @(posedge clock) begin
        n++;
        if (reset) begin
            for (int c = 0; c < NCH; c++) start_at[c] = -1;
            v_e = '0; v_l = '0; v_o = '0; v_m = '0; v_pass = 0;
            x_e = '0; x_l = '0; x_o = '0; x_m = '0;
            exp_err = 0; exp_pass = 0;
        end else begin
            if (enable) begin
                x_e = v_e; x_l = v_l; x_o = v_o; x_m = v_m;
                exp_err  = exp_err + $countones({v_e, v_l, v_o, v_m});
                exp_pass = exp_pass + v_pass;
                if (exp_err > 65535) exp_err = 65535;
                if (exp_pass > 65535) exp_pass = 65535;
            end else begin
                x_e = '0; x_l = '0; x_o = '0; x_m = '0;
            end
            v_e = '0; v_l = '0; v_o = '0; v_m = '0; v_pass = 0;
            for (int c = 0; c < NCH; c++) begin
                if (!enable) begin
                    start_at[c] = -1;
                end else if (start_at[c] < 0) begin
                    if (st[c]) start_at[c] = n;
                    else if (te[c]) v_m[c] = 1'b1;
                end else begin
                    int  k;
                    bit  done;
                    k    = n - start_at[c];
                    done = 1'b0;
                    if (te[c]) begin
                        done = 1'b1;
                        if (k < MINC) v_e[c] = 1'b1;
                        else v_pass++;
                    end else if (k == MAXC) begin
                        done = 1'b1;
                        v_l[c] = 1'b1;
                    end
                    if (done) start_at[c] = st[c] ? n : -1;
                    else if (st[c]) begin
                        v_o[c] = 1'b1;
                        start_at[c] = n;
                    end
                end
            end
        end
    end

    always @(negedge clock) begin
        if (chk_on) begin
            chk("fire_early",   32'(fire_early),   32'(x_e));
            chk("fire_late",    32'(fire_late),    32'(x_l));
            chk("fire_overlap", 32'(fire_overlap), 32'(x_o));
            chk("fire_missing", 32'(fire_missing), 32'(x_m));
            chk("err_count",    32'(err_count),    32'(exp_err));
`ifdef OVL_NEXT_WINDOW_COVER_EN
            chk("pass_count",   32'(pass_count),   32'(exp_pass));
`endif
        end
    end

    task automatic tick(input logic [NCH-1:0] s, input logic [NCH-1:0] t);
        @(negedge clock);
        st = s;
        te = t;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2'b00, 2'b00);
        reset = 1'b0;
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) tick(2'b00, 2'b00);
    endtask

    initial begin
        tick(2'b00, 2'b00);
        tick(2'b00, 2'b00);
        reset = 1'b0;
        chk_on = 1'b1;
        chk("reset_fire", 32'({fire_early, fire_late, fire_overlap, fire_missing}), 32'd0);
        chk("reset_err", 32'(err_count), 32'd0);

        // legal response at k=3
        do_reset();
        tick(2'b01, 2'b00);
        idle(2);
        tick(2'b00, 2'b01);
        idle(3);
        chk("legal_err", 32'(err_count), 32'd0);
`ifdef OVL_NEXT_WINDOW_COVER_EN
        chk("legal_pass", 32'(pass_count), 32'd1);
`endif

        // early on ch0, then late on ch1
        do_reset();
        tick(2'b01, 2'b00);
        tick(2'b00, 2'b01);
        tick(2'b00, 2'b00);
        chk("early_pulse", 32'(fire_early), 32'd1);
        tick(2'b10, 2'b00);
        idle(4);
        chk("late_not_yet", 32'(fire_late), 32'd0);
        tick(2'b00, 2'b00);
        chk("late_pulse", 32'(fire_late), 32'd2);
        idle(1);
        chk("early_late_err", 32'(err_count), 32'd2);

        // overlap restart, then pass at k=2 of the new window
        do_reset();
        tick(2'b01, 2'b00);
        tick(2'b00, 2'b00);
        tick(2'b01, 2'b00);
        tick(2'b00, 2'b00);
        chk("overlap_pulse", 32'(fire_overlap), 32'd1);
        chk("overlap_err", 32'(err_count), 32'd1);
        tick(2'b00, 2'b01);
        idle(4);
        chk("overlap_err_after", 32'(err_count), 32'd1);

        // pass and restart on the same edge, second window passes at k=3
        do_reset();
        tick(2'b01, 2'b00);
        tick(2'b00, 2'b00);
        tick(2'b01, 2'b01);
        idle(2);
        tick(2'b00, 2'b01);
        idle(5);
        chk("restart_err", 32'(err_count), 32'd0);
`ifdef OVL_NEXT_WINDOW_COVER_EN
        chk("restart_pass", 32'(pass_count), 32'd2);
`endif

        // missing start on both channels together
        do_reset();
        tick(2'b00, 2'b11);
        tick(2'b00, 2'b00);
        chk("missing_pulse", 32'(fire_missing), 32'd3);
        chk("missing_err", 32'(err_count), 32'd2);

        // disabled: responses ignored, count holds
        enable = 1'b0;
        tick(2'b00, 2'b11);
        tick(2'b01, 2'b11);
        tick(2'b00, 2'b00);
        chk("disabled_fire", 32'(fire_missing), 32'd0);
        chk("disabled_err", 32'(err_count), 32'd2);
        enable = 1'b1;
        idle(2);

        // reset in the middle of a window abandons it
        do_reset();
        tick(2'b01, 2'b00);
        tick(2'b00, 2'b00);
        reset = 1'b1;
        tick(2'b00, 2'b00);
        reset = 1'b0;
        idle(6);
        chk("midreset_err", 32'(err_count), 32'd0);
        chk("midreset_late", 32'(fire_late), 32'd0);

        // saturation: 65540 missing violations
        do_reset();
        for (int i = 0; i < 32770; i++) tick(2'b00, 2'b11);
        idle(3);
        chk("sat_err", 32'(err_count), 32'hFFFF);

        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
